// File: rtl/fifo_buffer_if.sv
// Handshake bundle between a FIFO producer/consumer (master) and the FIFO itself (slave).
interface fifo_buffer_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] Din;
    logic             WR_EN;
    logic             RD_EN;
    logic [WIDTH-1:0] Dout;
    logic             Empty;
    logic             Full;

    modport master (
        output Din,
        output WR_EN,
        output RD_EN,
        input  Dout,
        input  Empty,
        input  Full
    );

    modport slave (
        input  Din,
        input  WR_EN,
        input  RD_EN,
        output Dout,
        output Empty,
        output Full
    );
endinterface

// File: rtl/fifo_buffer.sv
// Synchronous single-clock FIFO with a registered read port and an occupancy count.
// The flags come straight from the count register; the storage array itself is never reset.
module fifo_buffer #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    fifo_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] dout_reg;

    logic is_empty;
    logic is_full;
    logic wr_ok;
    logic rd_ok;

    assign is_empty = (count == '0);
    assign is_full  = (count == CNT_FULL);

    // A write into a full FIFO is only taken when a read frees the slot on the same edge.
    assign rd_ok = bus.RD_EN && !is_empty;
    assign wr_ok = bus.WR_EN && (!is_full || rd_ok);

    always_ff @(posedge CLK) begin
        if (wr_ok && RST) begin
            mem[wr_ptr] <= bus.Din;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            dout_reg <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + 1'b1;
                dout_reg <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.Dout  = dout_reg;
    assign bus.Empty = is_empty;
    assign bus.Full  = is_full;
endmodule

// File: tb/tb_fifo_buffer.sv
// Self-checking bench for fifo_buffer: directed scenarios plus a randomized run against a queue model.
module tb_fifo_buffer;
    localparam int WIDTH = 10;
    localparam int DEPTH = 8;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    fifo_buffer_if #(.WIDTH(WIDTH)) bus ();

    fifo_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] exp_dout = '0;

    // One clock edge: drive, let the DUT sample, apply the FIFO rules to the model, settle.
    task automatic step(input logic rst_v, input logic wr, input logic rd, input logic [WIDTH-1:0] din);
        bit do_rd;
        bit do_wr;
        RST       = rst_v;
        bus.WR_EN = wr;
        bus.RD_EN = rd;
        bus.Din   = din;
        @(posedge CLK);
        if (!rst_v) begin
            model_q.delete();
            exp_dout = '0;
        end else begin
            do_rd = rd && (model_q.size() > 0);
            do_wr = wr && ((model_q.size() < DEPTH) || do_rd);
            if (do_rd) exp_dout = model_q.pop_front();
            if (do_wr) model_q.push_back(din);
        end
        #1;
        bus.WR_EN = 1'b0;
        bus.RD_EN = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        total++; if (bus.Empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty: got %b want 1", bus.Empty); end
        total++; if (bus.Full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full: got %b want 0", bus.Full); end
        total++; if (bus.Dout !== 10'd0) begin bad++; $display("[TB] FAIL reset_dout: got %0d want 0", bus.Dout); end
        step(1'b0, 1'b1, 1'b0, 10'd5);
        total++; if (bus.Empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_write_blocked: Empty got %b want 1", bus.Empty); end
        total++; if (dut.count !== 4'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", dut.count); end
    endtask

    task automatic test_basic_order();
        step(1'b1, 1'b1, 1'b0, 10'd32);
        step(1'b1, 1'b1, 1'b0, 10'd29);
        step(1'b1, 1'b1, 1'b0, 10'd53);
        step(1'b1, 1'b0, 1'b1, '0);
        total++; if (bus.Dout !== 10'd32) begin bad++; $display("[TB] FAIL basic_first: got %0d want 32", bus.Dout); end
        step(1'b1, 1'b1, 1'b0, 10'd32);
        step(1'b1, 1'b0, 1'b1, '0);
        total++; if (bus.Dout !== 10'd29) begin bad++; $display("[TB] FAIL basic_second: got %0d want 29", bus.Dout); end
        total++; if (bus.Empty !== 1'b0) begin bad++; $display("[TB] FAIL basic_empty: got %b want 0", bus.Empty); end
        total++; if (dut.count !== 4'd2) begin bad++; $display("[TB] FAIL basic_count: got %0d want 2", dut.count); end
        step(1'b1, 1'b0, 1'b1, '0);
        total++; if (bus.Dout !== 10'd53) begin bad++; $display("[TB] FAIL basic_third: got %0d want 53", bus.Dout); end
        step(1'b1, 1'b0, 1'b1, '0);
        total++; if (bus.Dout !== 10'd32) begin bad++; $display("[TB] FAIL basic_fourth: got %0d want 32", bus.Dout); end
        total++; if (bus.Empty !== 1'b1) begin bad++; $display("[TB] FAIL basic_drained: Empty got %b want 1", bus.Empty); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= DEPTH; i++) begin
            total++; if (bus.Full !== 1'b0) begin bad++; $display("[TB] FAIL fill_not_full_%0d: got %b want 0", i, bus.Full); end
            step(1'b1, 1'b1, 1'b0, WIDTH'(i));
        end
        total++; if (bus.Full !== 1'b1) begin bad++; $display("[TB] FAIL fill_full: got %b want 1", bus.Full); end
        step(1'b1, 1'b1, 1'b0, 10'd99);
        total++; if (dut.count !== 4'd8) begin bad++; $display("[TB] FAIL overflow_count: got %0d want 8", dut.count); end
        total++; if (bus.Full !== 1'b1) begin bad++; $display("[TB] FAIL overflow_full: got %b want 1", bus.Full); end
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, 1'b1, '0);
            total++; if (bus.Dout !== WIDTH'(i)) begin bad++; $display("[TB] FAIL drain_%0d: got %0d want %0d", i, bus.Dout, i); end
        end
        total++; if (bus.Empty !== 1'b1) begin bad++; $display("[TB] FAIL drain_empty: got %b want 1", bus.Empty); end
    endtask

    task automatic test_underflow();
        step(1'b1, 1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 1'b1, '0);
        total++; if (bus.Dout !== 10'd8) begin bad++; $display("[TB] FAIL underflow_dout: got %0d want 8", bus.Dout); end
        total++; if (bus.Empty !== 1'b1) begin bad++; $display("[TB] FAIL underflow_empty: got %b want 1", bus.Empty); end
        total++; if (dut.count !== 4'd0) begin bad++; $display("[TB] FAIL underflow_count: got %0d want 0", dut.count); end
    endtask

    task automatic test_simultaneous();
        step(1'b1, 1'b1, 1'b0, 10'd10);
        step(1'b1, 1'b1, 1'b0, 10'd11);
        step(1'b1, 1'b1, 1'b0, 10'd12);
        step(1'b1, 1'b1, 1'b1, 10'd13);
        total++; if (bus.Dout !== 10'd10) begin bad++; $display("[TB] FAIL simul_mid_dout: got %0d want 10", bus.Dout); end
        total++; if (dut.count !== 4'd3) begin bad++; $display("[TB] FAIL simul_mid_count: got %0d want 3", dut.count); end
        for (int i = 11; i <= 13; i++) begin
            step(1'b1, 1'b0, 1'b1, '0);
            total++; if (bus.Dout !== WIDTH'(i)) begin bad++; $display("[TB] FAIL simul_mid_drain: got %0d want %0d", bus.Dout, i); end
        end
        step(1'b1, 1'b1, 1'b1, 10'd7);
        total++; if (bus.Dout !== 10'd13) begin bad++; $display("[TB] FAIL simul_empty_dout: got %0d want 13", bus.Dout); end
        total++; if (dut.count !== 4'd1) begin bad++; $display("[TB] FAIL simul_empty_count: got %0d want 1", dut.count); end
        step(1'b1, 1'b0, 1'b1, '0);
        total++; if (bus.Dout !== 10'd7) begin bad++; $display("[TB] FAIL simul_empty_read: got %0d want 7", bus.Dout); end
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, WIDTH'(20 + i));
        step(1'b1, 1'b1, 1'b1, 10'd28);
        total++; if (bus.Dout !== 10'd20) begin bad++; $display("[TB] FAIL simul_full_dout: got %0d want 20", bus.Dout); end
        total++; if (bus.Full !== 1'b1) begin bad++; $display("[TB] FAIL simul_full_flag: got %b want 1", bus.Full); end
        for (int i = 21; i <= 28; i++) begin
            step(1'b1, 1'b0, 1'b1, '0);
            total++; if (bus.Dout !== WIDTH'(i)) begin bad++; $display("[TB] FAIL simul_full_drain: got %0d want %0d", bus.Dout, i); end
        end
    endtask

    task automatic test_wrap_reset();
        step(1'b1, 1'b1, 1'b0, WIDTH'($urandom));
        step(1'b1, 1'b1, 1'b0, WIDTH'($urandom));
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b1, WIDTH'($urandom));
            total++; if (bus.Dout !== exp_dout) begin bad++; $display("[TB] FAIL wrap_%0d: got %0d want %0d", i, bus.Dout, exp_dout); end
        end
        step(1'b1, 1'b1, 1'b0, WIDTH'($urandom));
        step(1'b1, 1'b1, 1'b0, WIDTH'($urandom));
        total++; if (dut.count !== 4'd4) begin bad++; $display("[TB] FAIL wrap_held: got %0d want 4", dut.count); end
        step(1'b0, 1'b0, 1'b0, '0);
        total++; if (bus.Empty !== 1'b1) begin bad++; $display("[TB] FAIL midreset_empty: got %b want 1", bus.Empty); end
        total++; if (bus.Dout !== 10'd0) begin bad++; $display("[TB] FAIL midreset_dout: got %0d want 0", bus.Dout); end
        step(1'b1, 1'b1, 1'b0, 10'd77);
        step(1'b1, 1'b0, 1'b1, '0);
        total++; if (bus.Dout !== 10'd77) begin bad++; $display("[TB] FAIL midreset_new_data: got %0d want 77", bus.Dout); end
        total++; if (bus.Empty !== 1'b1) begin bad++; $display("[TB] FAIL midreset_after: Empty got %b want 1", bus.Empty); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0), WIDTH'($urandom));
            total++; if (bus.Dout !== exp_dout) begin bad++; $display("[TB] FAIL rand_dout_%0d: got %0d want %0d", i, bus.Dout, exp_dout); end
            total++; if (dut.count !== 4'(model_q.size())) begin bad++; $display("[TB] FAIL rand_count_%0d: got %0d want %0d", i, dut.count, model_q.size()); end
            total++; if (bus.Empty !== (model_q.size() == 0)) begin bad++; $display("[TB] FAIL rand_empty_%0d: got %b", i, bus.Empty); end
            total++; if (bus.Full !== (model_q.size() == DEPTH)) begin bad++; $display("[TB] FAIL rand_full_%0d: got %b", i, bus.Full); end
        end
    endtask

    initial begin
        bus.Din   = '0;
        bus.WR_EN = 1'b0;
        bus.RD_EN = 1'b0;
        @(negedge CLK);
        test_reset();
        test_basic_order();
        test_fill_overflow();
        test_underflow();
        test_simultaneous();
        test_wrap_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
